// File: rtl/counter_pkg.sv
// Shared types and constants for the counter_nbits_mod family.
package counter_pkg;

    // Meaning of the `up` input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_t;

    localparam int COUNTER_DEFAULT_N = 8;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Next-value logic for counter_nbits_mod: one step up or down within 0..limit.
// A value above limit wraps to 0 when counting up, and walks down normally
// when counting down.
module counter_next
    import counter_pkg::*;
#(
    parameter int N = COUNTER_DEFAULT_N
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] limit,
    input  logic         up,
    output logic [N-1:0] next_val,
    output logic         wrap
);

    count_dir_t dir;

    assign dir = count_dir_t'(up);

    // Compute the enabled-step successor and flag a wrap.
    always_comb begin
        next_val = count;
        wrap     = 1'b0;
        if (dir == DIR_UP) begin
            if (count >= limit) begin
                next_val = '0;
                wrap     = 1'b1;
            end else begin
                next_val = count + 1'b1;
            end
        end else begin
            if (count == '0) begin
                next_val = limit;
                wrap     = 1'b1;
            end else begin
                next_val = count - 1'b1;
            end
        end
    end

endmodule : counter_next

// File: rtl/instancia_nbc_mod.sv
// Bring-up wrapper: 4-, 5- and 8-bit counters sharing clock, reset and controls.
// Carries each instance's ovf out when COUNTER_OVF_STICKY_EN is defined.
module instancia_nbc_mod (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val4,
    input  logic [3:0] limit4,
    input  logic [4:0] load_val5,
    input  logic [4:0] limit5,
    input  logic [7:0] load_val8,
    input  logic [7:0] limit8,
    output logic [3:0] count4,
    output logic [4:0] count5,
    output logic [7:0] count8,
    output logic       tc4,
    output logic       tc5,
    output logic       tc8,
    output logic       zero4,
    output logic       zero5,
    output logic       zero8
`ifdef COUNTER_OVF_STICKY_EN
    ,
    output logic       ovf4,
    output logic       ovf5,
    output logic       ovf8
`endif
);

    counter_nbits_mod #(.N(4)) u_cnt4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val4), .limit(limit4),
        .count(count4), .tc(tc4), .zero(zero4)
`ifdef COUNTER_OVF_STICKY_EN
        , .ovf(ovf4)
`endif
    );

    counter_nbits_mod #(.N(5)) u_cnt5 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val5), .limit(limit5),
        .count(count5), .tc(tc5), .zero(zero5)
`ifdef COUNTER_OVF_STICKY_EN
        , .ovf(ovf5)
`endif
    );

    counter_nbits_mod #(.N(8)) u_cnt8 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val8), .limit(limit8),
        .count(count8), .tc(tc8), .zero(zero8)
`ifdef COUNTER_OVF_STICKY_EN
        , .ovf(ovf8)
`endif
    );

endmodule : instancia_nbc_mod

// File: rtl/counter_nbits_mod.sv
// Parametrised N-bit up/down modulo counter with enable, synchronous load
// and a registered terminal-count pulse.
// Optional sticky wrap flag `ovf` is built when COUNTER_OVF_STICKY_EN is defined.
module counter_nbits_mod
    import counter_pkg::*;
#(
    parameter int          N         = COUNTER_DEFAULT_N,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         zero
`ifdef COUNTER_OVF_STICKY_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [N-1:0] RST_V = RESET_VAL[N-1:0];

    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic [N-1:0] step_val;
    logic         step_wrap;

    counter_next #(.N(N)) u_next (
        .count    (count_q),
        .limit    (limit),
        .up       (up),
        .next_val (step_val),
        .wrap     (step_wrap)
    );

    // Load beats enable; tc only pulses on an enabled wrap.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = step_val;
            tc_d    = step_wrap;
        end
    end

    // Count and terminal-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_V;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    assign ovf_d = (ovf_q & ~load) | tc_d;

    // Sticky wrap flag, cleared only by reset or load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);

endmodule : counter_nbits_mod

// File: doc/counter_nbits_mod.md
# counter_nbits_mod

Parametrised successor to the team's fixed free-running N-bit counter. It adds count enable, run-time up/down direction, synchronous parallel load and a run-time modulo limit, and emits a registered terminal-count pulse. It is the general-purpose counter for timers, prescalers and address generators in the lab designs. Several instances with different `N` sit side by side in one top-level wrapper.

## Interface
Parameters:
- `N`, 8: counter width in bits, N ≥ 2.
- `RESET_VAL`, 0: value `count` takes on reset; must be < 2**N.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable.
- `up` in 1: direction. 1 counts up, 0 counts down.
- `load` in 1: synchronous parallel load request.
- `load_val` in N: value loaded when `load`=1.
- `limit` in N: modulo limit; the count range is 0..limit inclusive.
- `count` out N: current count (registered).
- `tc` out 1: terminal-count pulse (registered), one cycle per wrap.
- `zero` out 1: combinational, `count == 0`.
- `ovf` out 1: present only with `COUNTER_OVF_STICKY_EN`; sticky wrap flag (registered).

## Operation
Priority per edge: `reset` > `load` > `en` > hold.
- **reset:** `count` ← `RESET_VAL`, `tc` ← 0, `ovf` ← 0.
- **load:** `count` ← `load_val`, `tc` ← 0, `ovf` ← 0. `en` and `up` are ignored that cycle.
- **en, up=1:**
  - if `count` ≥ `limit`: `count` ← 0, `tc` ← 1.
  - else: `count` ← `count`+1, `tc` ← 0.
- **en, up=0:**
  - if `count` == 0: `count` ← `limit`, `tc` ← 1.
  - else: `count` ← `count`−1, `tc` ← 0.
- **Hold** (`en`=0, no load/reset): `count` unchanged, `tc` ← 0.

Arithmetic and boundary rules:
- All arithmetic is unsigned N-bit; no carry-out port.
- `limit` = 2**N−1 gives plain binary wrap.
- `limit` = 0: `count` stays 0 and `tc`=1 on every enabled cycle, either direction.
- `count` > `limit` (after a load or a `limit` change), counting up: wraps to 0 on the next enabled edge with `tc`=1.
- `count` > `limit`, counting down: decrements normally until it reaches 0, then reloads `limit`.
- `limit` and `up` are sampled every edge; changing either mid-count takes effect on the next enabled edge, with no pipeline.
- `load` together with `reset`: reset wins.
- `load` together with `en`: load wins, so `count` = `load_val` exactly and there is no extra step.

## Timing
- **Latency:** `count` and `tc` update one cycle after the sampling edge.
- **`tc` alignment:** `tc` is high in the same cycle that the wrapped value (0 or `limit`) first appears on `count`.
- **Continuous counting:** with `en` held high, `tc` has period `limit`+1 cycles and a width of 1 cycle (except `limit`=0, where it stays high).
- **`zero`:** follows `count` combinationally with no extra delay.
- **Reset:** takes effect at the first rising edge with `reset`=1, including mid-count. Outputs are defined from the following cycle: `count`=`RESET_VAL`, `tc`=0, `ovf`=0, `zero`=(`RESET_VAL`==0).

## Configuration
- Macro `COUNTER_OVF_STICKY_EN`.
- **Defined:** port `ovf` exists. It sets to 1 on the same edge that `tc` is set, and stays 1 until `reset` or `load`.
- **Undefined:** port `ovf` and its register are absent. All other behaviour is identical.

## Structure
- **Package `counter_pkg`:**
  - typedef `count_dir_t` (`DIR_DOWN`=0, `DIR_UP`=1), used to interpret `up`.
  - default-width constant `COUNTER_DEFAULT_N` = 8.
- **Sub-module `counter_next`:** combinational. Takes `count`, `limit` and `up`; returns the next value and a wrap flag. The top holds only registers and priority logic.
- **Wrapper `instancia_nbc_mod`:** a test wrapper with N = 4, 5 and 8 instances, sharing `clk` and `reset`, for board bring-up.

## Test plan
- N=4, `limit`=15, `en`=1, `up`=1 from reset → `count` 0,1,…,15,0. `tc`=1 only in the cycle `count` returns to 0 (17th cycle after reset release).
- N=4, `limit`=9, `up`=0, load 3 → `count` 3,2,1,0,9,8; `tc`=1 in the cycle showing 9.
- N=8, `limit`=100, load 200 then `en`=1, `up`=1 → next `count`=0 with `tc`=1. Repeat with `up`=0: 199,198,… with no `tc` until 0→100.
- N=5, `limit`=0, `en`=1 → `count` stays 0, `tc`=1 every cycle, `zero`=1.
- `load`=1 and `en`=1 with `load_val`=7, then `reset`=1 mid-count at `count`=12 → `count`=7 first, then `RESET_VAL` on the edge after `reset`, `tc`=0.
- With `COUNTER_OVF_STICKY_EN`: N=4, `limit`=3, run 5 enabled cycles → `ovf` rises with the first `tc` and stays 1. `load` clears it. Without the macro, a netlist check confirms no `ovf` port.
